// File: rtl/forwarding_hazard_unit.sv
// Decode-to-execute hazard tracker.
// Remembers the destination registers of the instructions in EX, MEM and WB.
// For the instruction in decode it picks a bypass source for each operand and
// registers that choice, so the select is already valid when the instruction
// reaches EX. A load followed directly by a consumer of its result stalls decode
// for one cycle and puts a bubble into EX.

module forwarding_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      decode_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs2_i,
    input  logic                      decode_uses_rs1_i,
    input  logic                      decode_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rd_i,
    input  logic                      decode_reg_write_i,
    input  logic                      decode_is_load_i,
    input  logic                      stall_in_i,
    input  logic                      flush_i,
    output logic [2:0]                forward_control_rs1_o,
    output logic [2:0]                forward_control_rs2_o,
    output logic                      stall_decode_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

    // Bypass select encodings seen by the EX-stage operand multiplexers.
    localparam logic [2:0] SEL_REGFILE = 3'b000;
    localparam logic [2:0] SEL_EX      = 3'b001;
    localparam logic [2:0] SEL_MEM     = 3'b010;
    localparam logic [2:0] SEL_WB      = 3'b011;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hazState_t;

    // Per-slot tracking record. The load flag is only needed for the EX slot,
    // because a load can only cause a stall while it is one instruction ahead.
    typedef struct packed {
        logic                      valid;
        logic                      regWrite;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } slot_t;

    localparam slot_t BUBBLE = '{valid: 1'b0, regWrite: 1'b0, rd: '0};

    slot_t                 slot1_q, slot2_q, slot3_q;
    slot_t                 slot1_d;
    logic                  slot1Load_q, slot1Load_d;
    logic [2:0]            selRs1_q, selRs2_q;
    logic [2:0]            selRs1_d, selRs2_d;
    hazState_t             state_q;
    logic [CNT_WIDTH-1:0]  stallCycles_q;
    logic [CNT_WIDTH-1:0]  stallCyclesInc;

    logic match1Rs1, match2Rs1, match3Rs1;
    logic match1Rs2, match2Rs2, match3Rs2;
    logic hazard;
    logic advance;
    logic issue;

    // A slot only produces a value when it holds a real register-writing
    // instruction whose destination is not x0.
    function automatic logic isProducer(input slot_t s);
        return s.valid && s.regWrite && (s.rd != '0);
    endfunction

    // Operand match against one slot; unused operands never match.
    function automatic logic slotMatch(input slot_t s,
                                       input logic uses,
                                       input logic [REG_ADDR_WIDTH-1:0] rs);
        return uses && isProducer(s) && (s.rd == rs);
    endfunction

    // The youngest matching producer holds the newest value of the register.
    function automatic logic [2:0] pickSource(input logic m1,
                                              input logic m2,
                                              input logic m3);
        logic [2:0] sel;
        sel = SEL_REGFILE;
        if (m1) begin
            sel = SEL_EX;
        end else if (m2) begin
            sel = SEL_MEM;
        end else if (m3) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Compare both decode operands against every in-flight producer.
    always_comb begin
        match1Rs1 = slotMatch(slot1_q, decode_uses_rs1_i, decode_rs1_i);
        match2Rs1 = slotMatch(slot2_q, decode_uses_rs1_i, decode_rs1_i);
        match3Rs1 = slotMatch(slot3_q, decode_uses_rs1_i, decode_rs1_i);
        match1Rs2 = slotMatch(slot1_q, decode_uses_rs2_i, decode_rs2_i);
        match2Rs2 = slotMatch(slot2_q, decode_uses_rs2_i, decode_rs2_i);
        match3Rs2 = slotMatch(slot3_q, decode_uses_rs2_i, decode_rs2_i);
    end

    // Load-use detection and the resulting issue decision. While in LOAD_STALL
    // the EX slot already holds the bubble, so the hazard cannot re-arm there.
    always_comb begin
        hazard  = decode_valid_i && (state_q == RUN) && slot1Load_q &&
                  (match1Rs1 || match1Rs2);
        advance = !stall_in_i;
        issue   = decode_valid_i && !hazard && !flush_i;
    end

    // Next contents of the EX slot and the selects that travel with it.
    always_comb begin
        slot1_d     = BUBBLE;
        slot1Load_d = 1'b0;
        selRs1_d    = SEL_REGFILE;
        selRs2_d    = SEL_REGFILE;
        if (issue) begin
            slot1_d.valid    = 1'b1;
            slot1_d.regWrite = decode_reg_write_i;
            slot1_d.rd       = decode_rd_i;
            slot1Load_d      = decode_is_load_i;
            selRs1_d         = pickSource(match1Rs1, match2Rs1, match3Rs1);
            selRs2_d         = pickSource(match1Rs2, match2Rs2, match3Rs2);
        end
    end

    // Saturating increment of the stall counter.
    always_comb begin
        stallCyclesInc = stallCycles_q;
        if (stallCycles_q != '1) begin
            stallCyclesInc = stallCycles_q + 1'b1;
        end
    end

    // Shift the in-flight slots and register the bypass selects on advance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot1_q     <= BUBBLE;
            slot2_q     <= BUBBLE;
            slot3_q     <= BUBBLE;
            slot1Load_q <= 1'b0;
            selRs1_q    <= SEL_REGFILE;
            selRs2_q    <= SEL_REGFILE;
        end else if (advance) begin
            slot3_q     <= slot2_q;
            slot2_q     <= slot1_q;
            slot1_q     <= slot1_d;
            slot1Load_q <= slot1Load_d;
            selRs1_q    <= selRs1_d;
            selRs2_q    <= selRs2_d;
        end
    end

    // Load-use FSM with the stall-cycle counter; both freeze with the pipeline.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= RUN;
            stallCycles_q <= '0;
        end else if (advance) begin
            if (hazard) begin
                stallCycles_q <= stallCyclesInc;
            end
            case (state_q)
                RUN: begin
                    if (hazard && !flush_i) begin
                        state_q <= LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign stall_decode_o        = stall_in_i || hazard;
    assign forward_control_rs1_o = selRs1_q;
    assign forward_control_rs2_o = selRs2_q;
    assign stall_cycles_o        = stallCycles_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed pipeline scenarios followed by
// randomized traffic, all checked against a history-of-issued-instructions model.

module tb_forwarding_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          decode_valid_i;
    logic [AW-1:0] decode_rs1_i;
    logic [AW-1:0] decode_rs2_i;
    logic          decode_uses_rs1_i;
    logic          decode_uses_rs2_i;
    logic [AW-1:0] decode_rd_i;
    logic          decode_reg_write_i;
    logic          decode_is_load_i;
    logic          stall_in_i;
    logic          flush_i;
    logic [2:0]    forward_control_rs1_o;
    logic [2:0]    forward_control_rs2_o;
    logic          stall_decode_o;
    logic [CW-1:0] stall_cycles_o;

    forwarding_hazard_unit #(
        .REG_ADDR_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .decode_valid_i        (decode_valid_i),
        .decode_rs1_i          (decode_rs1_i),
        .decode_rs2_i          (decode_rs2_i),
        .decode_uses_rs1_i     (decode_uses_rs1_i),
        .decode_uses_rs2_i     (decode_uses_rs2_i),
        .decode_rd_i           (decode_rd_i),
        .decode_reg_write_i    (decode_reg_write_i),
        .decode_is_load_i      (decode_is_load_i),
        .stall_in_i            (stall_in_i),
        .flush_i               (flush_i),
        .forward_control_rs1_o (forward_control_rs1_o),
        .forward_control_rs2_o (forward_control_rs2_o),
        .stall_decode_o        (stall_decode_o),
        .stall_cycles_o        (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: the issued instructions still in flight, index 0 = one ahead.
    typedef struct packed {
        logic          prod;
        logic [AW-1:0] rd;
        logic          load;
    } instRec_t;

    instRec_t      history [3];
    logic [2:0]    expSel1 = 3'd0;
    logic [2:0]    expSel2 = 3'd0;
    logic [CW-1:0] expCnt  = '0;
    int            compared   = 0;
    int            mismatched = 0;

    // Distance (1..3) to the youngest in-flight writer of rs, 0 if none.
    function automatic int distanceOf(input logic uses, input logic [AW-1:0] rs);
        if (!uses || rs == '0) return 0;
        for (int d = 0; d < 3; d++) begin
            if (history[d].prod && history[d].rd == rs) return d + 1;
        end
        return 0;
    endfunction

    function automatic logic modelHazard();
        return decode_valid_i && history[0].load &&
               (distanceOf(decode_uses_rs1_i, decode_rs1_i) == 1 ||
                distanceOf(decode_uses_rs2_i, decode_rs2_i) == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv,
                                 input logic [AW-1:0] rs1, input logic u1,
                                 input logic [AW-1:0] rs2, input logic u2,
                                 input logic [AW-1:0] rd, input logic rw, input logic ld,
                                 input logic st, input logic fl, input logic rst);
        decode_valid_i     = dv;
        decode_rs1_i       = rs1;
        decode_uses_rs1_i  = u1;
        decode_rs2_i       = rs2;
        decode_uses_rs2_i  = u2;
        decode_rd_i        = rd;
        decode_reg_write_i = rw;
        decode_is_load_i   = ld;
        stall_in_i         = st;
        flush_i            = fl;
        reset_i            = rst;
    endtask

    // Check the combinational stall, clock once, advance the model, check the registers.
    task automatic checkOutput(input string tag);
        logic hz;
        logic iss;
        int   d1;
        int   d2;
        #1;
        hz = modelHazard();
        check({tag, ".stall"}, {31'd0, stall_decode_o}, {31'd0, stall_in_i | hz});
        d1 = distanceOf(decode_uses_rs1_i, decode_rs1_i);
        d2 = distanceOf(decode_uses_rs2_i, decode_rs2_i);
        @(posedge clk_i);
        if (reset_i) begin
            for (int i = 0; i < 3; i++) history[i] = '0;
            expSel1 = 3'd0;
            expSel2 = 3'd0;
            expCnt  = '0;
        end else if (!stall_in_i) begin
            if (hz && expCnt != {CW{1'b1}}) expCnt = expCnt + 1'b1;
            iss = decode_valid_i && !hz && !flush_i;
            history[2] = history[1];
            history[1] = history[0];
            history[0] = iss ? {decode_reg_write_i && decode_rd_i != '0, decode_rd_i, decode_is_load_i}
                             : '0;
            expSel1 = iss ? d1[2:0] : 3'd0;
            expSel2 = iss ? d2[2:0] : 3'd0;
        end
        #1;
        check({tag, ".sel1"}, {29'd0, forward_control_rs1_o}, {29'd0, expSel1});
        check({tag, ".sel2"}, {29'd0, forward_control_rs2_o}, {29'd0, expSel2});
        check({tag, ".cnt"}, {28'd0, stall_cycles_o}, {28'd0, expCnt});
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) history[i] = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset");
        check("reset.sel1k", {29'd0, forward_control_rs1_o}, 32'd0);
        check("reset.cntk", {28'd0, stall_cycles_o}, 32'd0);

        // ALU dependence: ADD x5 then SUB reading x5
        applyStimulus(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        checkOutput("add");
        applyStimulus(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0);
        checkOutput("sub");
        check("alu.sel1k", {29'd0, forward_control_rs1_o}, 32'd1);
        check("alu.sel2k", {29'd0, forward_control_rs2_o}, 32'd0);

        // Distance 2: x7 producer, one independent, consumer on rs2
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
        checkOutput("d2.prod");
        applyStimulus(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0);
        checkOutput("d2.ind");
        applyStimulus(1, 1, 1, 7, 1, 11, 1, 0, 0, 0, 0);
        checkOutput("d2.cons");
        check("d2.sel2k", {29'd0, forward_control_rs2_o}, 32'd2);
        check("d2.sel1k", {29'd0, forward_control_rs1_o}, 32'd0);

        // Distance 3: x7 producer, two independent, consumer on rs2
        applyStimulus(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
        checkOutput("d3.prod");
        applyStimulus(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0);
        checkOutput("d3.ind1");
        applyStimulus(1, 1, 1, 2, 1, 10, 1, 0, 0, 0, 0);
        checkOutput("d3.ind2");
        applyStimulus(1, 1, 1, 7, 1, 11, 1, 0, 0, 0, 0);
        checkOutput("d3.cons");
        check("d3.sel2k", {29'd0, forward_control_rs2_o}, 32'd3);

        // Load-use: LW x3 then ADD x4,x3,x3 held for the stall cycle
        applyStimulus(1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0);
        checkOutput("lw");
        applyStimulus(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0);
        #1 check("lu.stallk", {31'd0, stall_decode_o}, 32'd1);
        checkOutput("lu.bubble");
        check("lu.bubsel1k", {29'd0, forward_control_rs1_o}, 32'd0);
        check("lu.cntk", {28'd0, stall_cycles_o}, 32'd1);
        #1 check("lu.unstallk", {31'd0, stall_decode_o}, 32'd0);
        checkOutput("lu.issue");
        check("lu.sel1k", {29'd0, forward_control_rs1_o}, 32'd2);
        check("lu.sel2k", {29'd0, forward_control_rs2_o}, 32'd2);

        // Priority: two writers of x9, consumer sees the youngest
        applyStimulus(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        checkOutput("pri.w1");
        applyStimulus(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        checkOutput("pri.w2");
        applyStimulus(1, 9, 1, 9, 1, 13, 1, 0, 0, 0, 0);
        checkOutput("pri.cons");
        check("pri.sel1k", {29'd0, forward_control_rs1_o}, 32'd1);

        // x0: a load to x0 followed by a consumer of x0
        applyStimulus(1, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0);
        checkOutput("x0.lw");
        applyStimulus(1, 0, 1, 0, 1, 14, 1, 0, 0, 0, 0);
        #1 check("x0.stallk", {31'd0, stall_decode_o}, 32'd0);
        checkOutput("x0.cons");
        check("x0.sel1k", {29'd0, forward_control_rs1_o}, 32'd0);

        // stall_in freeze with a 001 select registered
        applyStimulus(1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0);
        checkOutput("frz.prod");
        applyStimulus(1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0);
        checkOutput("frz.cons");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 12, 1, 2, 1, 13, 1, 0, 1, 0, 0);
            checkOutput("frz.hold");
            check("frz.sel1k", {29'd0, forward_control_rs1_o}, 32'd1);
        end
        applyStimulus(1, 12, 1, 2, 1, 13, 1, 0, 0, 0, 0);
        checkOutput("frz.resume");

        // Flush coincident with a load-use hazard
        applyStimulus(1, 1, 1, 2, 1, 15, 1, 1, 0, 0, 0);
        checkOutput("fl.lw");
        applyStimulus(1, 15, 1, 2, 1, 16, 1, 0, 0, 1, 0);
        checkOutput("fl.hz");
        check("fl.sel1k", {29'd0, forward_control_rs1_o}, 32'd0);
        applyStimulus(1, 15, 1, 2, 1, 16, 1, 0, 0, 0, 0);
        checkOutput("fl.next");

        // Reset in the middle of a load-use stall
        applyStimulus(1, 1, 1, 2, 1, 17, 1, 1, 0, 0, 0);
        checkOutput("rs.lw");
        applyStimulus(1, 17, 1, 2, 1, 18, 1, 0, 0, 0, 0);
        checkOutput("rs.hz");
        applyStimulus(1, 17, 1, 2, 1, 18, 1, 0, 0, 0, 1);
        checkOutput("rs.reset");
        check("rs.cntk", {28'd0, stall_cycles_o}, 32'd0);
        applyStimulus(1, 17, 1, 2, 1, 18, 1, 0, 0, 0, 0);
        #1 check("rs.stallk", {31'd0, stall_decode_o}, 32'd0);
        checkOutput("rs.after");

        // Randomized traffic over a small register set to force many matches
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 99) < 85),
                          AW'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
                          AW'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                          AW'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 99) < 15),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 2));
            checkOutput("rand");
        end

        // Counter saturation: 18 load-use stalls after a reset
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("sat.reset");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1, 1, 1, 2, 1, 20, 1, 1, 0, 0, 0);
            checkOutput("sat.lw");
            applyStimulus(1, 20, 1, 2, 1, 21, 1, 0, 0, 0, 0);
            checkOutput("sat.hz");
            applyStimulus(1, 20, 1, 2, 1, 21, 1, 0, 0, 0, 0);
            checkOutput("sat.issue");
        end
        check("sat.cntk", {28'd0, stall_cycles_o}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
